// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexes the two digit patterns from timer_counter
// onto one shared segment bus. Both digits are snapshotted once per frame, each
// digit slot is preceded by a dark gap against ghosting, and an optional
// leading-zero tens digit is kept dark.
module seven_seg_scanner #(
  parameter int         REFRESH_DIV     = 50000,
  parameter int         BLANK_CYCLES    = 500,
  parameter bit         SEG_ACTIVE_LOW  = 1'b1,
  parameter bit         AN_ACTIVE_LOW   = 1'b1,
  parameter bit         BLANK_TENS_ZERO = 1'b1,
  parameter logic [6:0] ZERO_PATTERN    = 7'b1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [6:0] digit_units,
  input  logic [6:0] digit_tens,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_done
);

  localparam int MAX_COUNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW        = $clog2(MAX_COUNT + 1);

  localparam logic [CW-1:0] REFRESH_LOAD = CW'(REFRESH_DIV);
  localparam logic [CW-1:0] BLANK_LOAD   = CW'(BLANK_CYCLES);
  localparam logic [CW-1:0] ONE          = CW'(1);

  localparam logic [6:0] SEG_DARK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0] AN_OFF   = AN_ACTIVE_LOW ? 2'b11 : 2'b00;
  localparam logic [1:0] AN_UNITS = AN_OFF ^ 2'b01;
  localparam logic [1:0] AN_TENS  = AN_OFF ^ 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    BLANK_U,
    SHOW_U,
    BLANK_T,
    SHOW_T
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] count;
  logic [CW-1:0] next_count;
  logic [6:0]    u_q;
  logic [6:0]    t_q;
  logic [6:0]    u_next;
  logic [6:0]    t_next;
  logic [6:0]    seg_next;
  logic [1:0]    an_next;
  logic          frame_done_next;
  logic          last_cycle;

  assign last_cycle = (count == ONE);

  // The snapshot taken at the end of LATCH must already be visible when the
  // registered outputs are computed for the following state.
  assign u_next = (state == LATCH) ? digit_units : u_q;
  assign t_next = (state == LATCH) ? digit_tens  : t_q;

  // State and slot counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= next_state;
      count <= next_count;
    end
  end

  // Digit snapshot registers, only ever updated by the LATCH cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      u_q <= 7'h7F;
      t_q <= 7'h7F;
    end else begin
      u_q <= u_next;
      t_q <= t_next;
    end
  end

  // Next-state and counter: each state is timed by a down-counter loaded on entry.
  always_comb begin
    next_state = state;
    next_count = count;
    if (!enable) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = LATCH;
        LATCH:   next_state = (BLANK_CYCLES == 0) ? SHOW_U : BLANK_U;
        BLANK_U: if (last_cycle) next_state = SHOW_U;
        SHOW_U:  if (last_cycle) next_state = (BLANK_CYCLES == 0) ? SHOW_T : BLANK_T;
        BLANK_T: if (last_cycle) next_state = SHOW_T;
        SHOW_T:  if (last_cycle) next_state = LATCH;
        default: next_state = IDLE;
      endcase
    end
    if (next_state != state) begin
      case (next_state)
        LATCH:            next_count = ONE;
        BLANK_U, BLANK_T: next_count = BLANK_LOAD;
        SHOW_U, SHOW_T:   next_count = REFRESH_LOAD;
        default:          next_count = '0;
      endcase
    end else if (count != '0) begin
      next_count = count - ONE;
    end
  end

  // Output decode from the upcoming state so registered outputs line up with it.
  always_comb begin
    seg_next        = SEG_DARK;
    an_next         = AN_OFF;
    frame_done_next = 1'b0;
    case (next_state)
      SHOW_U: begin
        seg_next = SEG_ACTIVE_LOW ? u_next : ~u_next;
        an_next  = AN_UNITS;
      end
      SHOW_T: begin
        if (!(BLANK_TENS_ZERO && (t_next == ZERO_PATTERN))) begin
          seg_next = SEG_ACTIVE_LOW ? t_next : ~t_next;
          an_next  = AN_TENS;
        end
        frame_done_next = (next_count == ONE);
      end
      default: begin
        seg_next = SEG_DARK;
        an_next  = AN_OFF;
      end
    endcase
  end

  // Registered outputs; reset darkens the display immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg        <= SEG_DARK;
      an         <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_next;
      an         <= an_next;
      frame_done <= frame_done_next;
    end
  end

endmodule
